noc_link_tx_arbiter: RTL and testbench

- Shares one NoC link transmitter among `NUM_REQ` local requesters. Each requester is a module-side port such as a DTU, config master or debug port.
- Round-robin arbitration per packet. A burst (multi-flit packet) keeps the grant until its last flit, so flits of different bursts never interleave on the link.
- Sits directly in front of the link PHY TX port, in the same `clk_i` domain, and honours the PHY FIFO-full stall.
- A watchdog releases a lock held by a requester that stops supplying flits mid-burst, and flags the error.

---
 rtl/noc_link_tx_arbiter_pkg.sv | 11 +
 rtl/noc_link_tx_arbiter_if.sv | 20 ++
 rtl/noc_link_tx_arbiter_rr_prio_select.sv | 30 +++
 rtl/noc_link_tx_arbiter.sv | 86 ++++++++
 tb/tb_noc_link_tx_arbiter.sv | 158 +++++++++++++++
 5 files changed

// File: rtl/noc_link_tx_arbiter_pkg.sv
// noc_link_tx_arbiter_pkg: shared NoC sizes, burst bit, flit struct and arbiter FSM states
package noc_link_tx_arbiter_pkg;
  localparam int NOC_HEADER_SIZE = 16;
  localparam int NOC_PAYLOAD_SIZE = 32;
  localparam int BURST_BIT = 15;
  typedef struct packed {
    logic [NOC_HEADER_SIZE-1:0] header;
    logic [NOC_PAYLOAD_SIZE-1:0] payload;
  } flit_t;
  typedef enum logic {IDLE, LOCKED} arb_state_e;
endpackage

// File: rtl/noc_link_tx_arbiter_if.sv
// noc_link_tx_arbiter_if: requester flits in (valid/header/payload/ack), PHY TX out (wrreq/header/payload/stall)
interface noc_link_tx_arbiter_if #(parameter int NUM_REQ = 4);
  import noc_link_tx_arbiter_pkg::*;
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*NOC_HEADER_SIZE-1:0] req_header;
  logic [NUM_REQ*NOC_PAYLOAD_SIZE-1:0] req_payload;
  logic [NUM_REQ-1:0] req_ack;
  logic tx_wrreq;
  logic [NOC_HEADER_SIZE-1:0] tx_header;
  logic [NOC_PAYLOAD_SIZE-1:0] tx_payload;
  logic tx_stall;
  modport master (
    output req_valid, req_header, req_payload, tx_stall,
    input req_ack, tx_wrreq, tx_header, tx_payload
  );
  modport slave (
    input req_valid, req_header, req_payload, tx_stall,
    output req_ack, tx_wrreq, tx_header, tx_payload
  );
endinterface

// File: rtl/noc_link_tx_arbiter_rr_prio_select.sv
// rr_prio_select: first valid at or after ptr_i (mod N); in valid_i/ptr_i, out one-hot grant_o, idx_o, any_o
module rr_prio_select #(
  parameter int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] valid_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] grant_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);
  logic [W-1:0] rot [N];
  for (genvar k = 0; k < N; k++) begin : g_rot
    logic [W:0] s;
    assign s = {1'b0, ptr_i} + (W+1)'(k);
    assign rot[k] = W'(s >= (W+1)'(N) ? s - (W+1)'(N) : s);
  end
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any_o && valid_i[rot[k]]) begin
        any_o = 1'b1;
        idx_o = rot[k];
        grant_o[rot[k]] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/noc_link_tx_arbiter.sv
// noc_link_tx_arbiter: round-robin per-packet link TX arbiter with burst lock and gap watchdog; clk_i, rst_q_i, bus (slave), gap_err_o, gap_err_clr_i
module noc_link_tx_arbiter
  import noc_link_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_q_i,
  noc_link_tx_arbiter_if.slave bus,
  output logic gap_err_o,
  input  logic gap_err_clr_i
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int GW = $clog2(GAP_TIMEOUT + 1);
  arb_state_e state_q, state_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d, owner_q, owner_d, pick_idx, cand_idx;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic gap_err_q, gap_err_d;
  logic [NUM_REQ-1:0] pick_oh;
  logic pick_any, cand_any, xfer, burst, locked;
  flit_t flit [NUM_REQ];
  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] x);
    return x == PW'(NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_flit
    assign flit[i] = {bus.req_header[i*NOC_HEADER_SIZE +: NOC_HEADER_SIZE],
                      bus.req_payload[i*NOC_PAYLOAD_SIZE +: NOC_PAYLOAD_SIZE]};
  end
  rr_prio_select #(.N(NUM_REQ)) u_sel (
    .valid_i(bus.req_valid),
    .ptr_i  (rr_ptr_q),
    .grant_o(pick_oh),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );
  assign locked = state_q == LOCKED;
  assign cand_any = locked ? bus.req_valid[owner_q] : pick_any;
  assign cand_idx = locked ? owner_q : pick_idx;
  assign xfer = rst_q_i && cand_any && !bus.tx_stall;
  assign burst = flit[cand_idx].header[BURST_BIT];
  assign bus.tx_wrreq = xfer;
  assign bus.req_ack = !xfer ? '0 : locked ? NUM_REQ'(1) << owner_q : pick_oh;
  assign bus.tx_header = flit[cand_idx].header;
  assign bus.tx_payload = flit[cand_idx].payload;
  assign gap_err_o = gap_err_q;
  always_comb begin
    state_d = state_q;
    rr_ptr_d = rr_ptr_q;
    owner_d = owner_q;
    gap_cnt_d = gap_cnt_q;
    gap_err_d = gap_err_q && !gap_err_clr_i;
    if (xfer) begin
      state_d = burst ? LOCKED : IDLE;
      owner_d = burst ? cand_idx : owner_q;
      gap_cnt_d = '0;
      rr_ptr_d = burst ? rr_ptr_q : wrap_inc(cand_idx);
    end else if (locked) begin
      if (bus.req_valid[owner_q]) begin
        gap_cnt_d = '0;
      end else if (gap_cnt_q == GW'(GAP_TIMEOUT - 1)) begin
        state_d = IDLE;
        rr_ptr_d = wrap_inc(owner_q);
        gap_cnt_d = '0;
        gap_err_d = 1'b1;
      end else begin
        gap_cnt_d = gap_cnt_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk_i or negedge rst_q_i) begin
    if (!rst_q_i) begin
      state_q <= IDLE;
      rr_ptr_q <= '0;
      owner_q <= '0;
      gap_cnt_q <= '0;
      gap_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q <= owner_d;
      gap_cnt_q <= gap_cnt_d;
      gap_err_q <= gap_err_d;
    end
  end
endmodule

// File: tb/tb_noc_link_tx_arbiter.sv
// tb_noc_link_tx_arbiter: directed and random checks of the link arbiter against a packet-level reference model
module tb_noc_link_tx_arbiter;
  import noc_link_tx_arbiter_pkg::*;
  localparam int N = 4;
  localparam int T = 8;
  localparam int H = NOC_HEADER_SIZE;
  localparam int P = NOC_PAYLOAD_SIZE;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic gap_err;
  logic gap_err_clr = 1'b0;
  int checks = 0;
  int failures = 0;
  bit m_locked, m_err;
  int m_owner, m_ptr, m_gap;
  always #5 clk = ~clk;
  noc_link_tx_arbiter_if #(.NUM_REQ(N)) bus ();
  noc_link_tx_arbiter #(.NUM_REQ(N), .GAP_TIMEOUT(T)) dut (
    .clk_i        (clk),
    .rst_q_i      (rst_n),
    .bus          (bus),
    .gap_err_o    (gap_err),
    .gap_err_clr_i(gap_err_clr)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input bit v, input bit b);
    logic [H-1:0] h;
    h = H'($urandom);
    h[BURST_BIT] = b;
    bus.req_valid[i] = v;
    bus.req_header[i*H +: H] = h;
    bus.req_payload[i*P +: P] = P'($urandom);
  endtask
  task automatic all_req(input logic [N-1:0] v, input logic [N-1:0] b);
    for (int i = 0; i < N; i++) set_req(i, v[i], b[i]);
  endtask
  task automatic cycle(input string tag, input int exp_ack = -1);
    int c;
    bit any, x;
    @(negedge clk);
    if (!rst_n) begin
      m_locked = 0; m_err = 0; m_owner = 0; m_ptr = 0; m_gap = 0;
    end
    any = 0;
    c = 0;
    if (m_locked) begin
      any = bus.req_valid[m_owner];
      c = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (!any && bus.req_valid[(m_ptr + k) % N]) begin
          any = 1;
          c = (m_ptr + k) % N;
        end
    end
    x = any && !bus.tx_stall && rst_n;
    chk({tag, ".wrreq"}, 64'(bus.tx_wrreq), 64'(x));
    chk({tag, ".ack"}, 64'(bus.req_ack), x ? 64'(1) << c : 64'(0));
    chk({tag, ".gap_err"}, 64'(gap_err), 64'(m_err));
    if (exp_ack >= 0) chk({tag, ".dir_ack"}, 64'(bus.req_ack), 64'(exp_ack));
    if (x) begin
      chk({tag, ".hdr"}, 64'(bus.tx_header), 64'(bus.req_header[c*H +: H]));
      chk({tag, ".pay"}, 64'(bus.tx_payload), 64'(bus.req_payload[c*P +: P]));
    end
    @(posedge clk);
    if (rst_n) begin
      m_err = m_err && !gap_err_clr;
      if (x) begin
        if (bus.req_header[c*H + BURST_BIT]) begin
          m_locked = 1; m_owner = c; m_gap = 0;
        end else begin
          m_locked = 0; m_ptr = (c + 1) % N;
        end
      end else if (m_locked) begin
        if (bus.req_valid[m_owner]) m_gap = 0;
        else begin
          m_gap++;
          if (m_gap == T) begin
            m_locked = 0; m_ptr = (m_owner + 1) % N; m_err = 1; m_gap = 0;
          end
        end
      end
    end
    #1;
  endtask
  initial begin
    bus.tx_stall = 1'b0;
    all_req('1, '0);
    cycle("reset", 0);
    cycle("reset2", 0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      all_req('1, '0);
      cycle("rr", 1 << (k % N));
    end
    all_req(4'b0001, '0);
    cycle("pre_burst", 1);
    all_req('1, 4'b0010);
    cycle("burst_a", 2);
    all_req('1, 4'b0010);
    cycle("burst_b", 2);
    all_req('1, '0);
    cycle("burst_c", 2);
    all_req('1, '0);
    cycle("after_burst", 4);
    all_req(4'b0001, '0);
    bus.tx_stall = 1'b1;
    for (int k = 0; k < 5; k++) cycle("stall", 0);
    bus.tx_stall = 1'b0;
    cycle("stall_rel", 1);
    all_req(4'b1000, 4'b1000);
    cycle("wd_lock", 8);
    all_req(4'b0111, '0);
    for (int k = 0; k < T; k++) cycle("wd_gap", 0);
    chk("wd_err_set", 64'(gap_err), 64'(1));
    cycle("wd_next", 1);
    gap_err_clr = 1'b1;
    all_req('0, '0);
    cycle("wd_clr", 0);
    gap_err_clr = 1'b0;
    chk("wd_err_cleared", 64'(gap_err), 64'(0));
    all_req(4'b0100, 4'b0100);
    cycle("sb_lock", 4);
    bus.tx_stall = 1'b1;
    all_req('1, 4'b0100);
    for (int k = 0; k < 20; k++) cycle("sb_stall", 0);
    bus.tx_stall = 1'b0;
    cycle("sb_mid", 4);
    all_req('1, '0);
    cycle("sb_end", 4);
    chk("sb_no_err", 64'(gap_err), 64'(0));
    all_req('1, '0);
    cycle("sb_after", 8);
    all_req(4'b0010, 4'b0010);
    cycle("rb_lock", 2);
    rst_n = 1'b0;
    all_req('1, '1);
    cycle("rb_rst", 0);
    rst_n = 1'b1;
    all_req('1, '0);
    cycle("rb_after", 1);
    for (int k = 0; k < 600; k++) begin
      bus.tx_stall = $urandom_range(3) == 0;
      gap_err_clr = $urandom_range(15) == 0;
      for (int i = 0; i < N; i++)
        set_req(i, k < 400 ? $urandom_range(9) < 7 : $urandom_range(9) < 2, $urandom_range(2) == 0);
      cycle("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
